vram_display_reader: RTL

- Display-side reader of the 320x240x12 frame buffer that the camera capture path fills.
- Generates 640x480@60 VGA timing from a divided pixel tick.
- Issues read addresses to the VRAM read port, with each stored pixel shown as a 2x2 block.
- Drives 4-bit R/G/B plus sync, aligned to the synchronous-RAM read latency.

---
 rtl/vram_display_reader.sv | 118 +++++++++++
 1 files changed

// File: rtl/vram_display_reader.sv
// vram_display_reader: 640x480@60 VGA scan of a 320x240 RGB444 frame buffer, each stored pixel shown as 2x2.
// Optional `define TEST_PATTERN_EN adds test_pattern_i, which swaps VRAM data for 8 vertical colour bars.
module vram_display_reader #(
  parameter int ADDR_WIDTH = $clog2(76800),
  parameter int DATA_WIDTH = 12,
  parameter int CLK_DIV = 4,
  parameter int FB_WIDTH = 320,
  parameter int FB_HEIGHT = 240
) (
  input  logic clk_i,
  input  logic reset_n_i,
`ifdef TEST_PATTERN_EN
  input  logic test_pattern_i,
`endif
  output logic [ADDR_WIDTH-1:0] pixel_read_address_o,
  input  logic [DATA_WIDTH-1:0] pixel_data_i,
  output logic hsync_o,
  output logic vsync_o,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o,
  output logic video_active_o,
  output logic frame_start_o
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, row, prod;
  logic tick, active, h_end, v_end;
  logic t1_q, t1_d, t2_q, t2_d;
  logic act_q, act_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [11:0] pix, rgb_q, rgb_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d, frame_q, frame_d;
`ifdef TEST_PATTERN_EN
  logic [2:0] bar_q, bar_d;
`endif
  always_comb begin
    tick = div_q == DW'(CLK_DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    h_end = h_q == 10'd799;
    v_end = v_q == 10'd524;
    h_d = tick ? (h_end ? '0 : h_q + 10'd1) : h_q;
    v_d = (tick && h_end) ? (v_end ? '0 : v_q + 10'd1) : v_q;
    active = h_q < 10'(2 * FB_WIDTH) && v_q < 10'(2 * FB_HEIGHT);
    row = ADDR_WIDTH'(v_q[9:1]);
    prod = '0;
    // constant shift-add multiply by FB_WIDTH, so no hardware multiplier is inferred
    for (int i = 0; i < ADDR_WIDTH; i++) prod = FB_WIDTH[i] ? prod + (row << i) : prod;
    addr_d = (tick && active) ? prod + ADDR_WIDTH'(h_q[9:1]) : addr_q;
    t1_d = tick;
    t2_d = t1_q;
    act_d = tick ? active : act_q;
    hs_d = tick ? !(h_q >= 10'd656 && h_q <= 10'd751) : hs_q;
    vs_d = tick ? !(v_q >= 10'd490 && v_q <= 10'd491) : vs_q;
    fs_d = tick ? (h_q == '0 && v_q == '0) : fs_q;
`ifdef TEST_PATTERN_EN
    bar_d = tick ? 3'(h_q / 10'd80) : bar_q;
    pix = test_pattern_i ? {{4{bar_q[2]}}, {4{bar_q[1]}}, {4{bar_q[0]}}} : pixel_data_i[11:0];
`else
    pix = pixel_data_i[11:0];
`endif
    // stage-0 flags are stable until the next tick (CLK_DIV >= 3), so stage 2 reads them directly
    rgb_d = t2_q ? (act_q ? pix : 12'h000) : rgb_q;
    hsync_d = t2_q ? hs_q : hsync_q;
    vsync_d = t2_q ? vs_q : vsync_q;
    video_d = t2_q ? act_q : video_q;
    frame_d = t2_q && fs_q;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      div_q <= '0;
      h_q <= '0;
      v_q <= '0;
      addr_q <= '0;
      t1_q <= 1'b0;
      t2_q <= 1'b0;
      act_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fs_q <= 1'b0;
      rgb_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b0;
      frame_q <= 1'b0;
`ifdef TEST_PATTERN_EN
      bar_q <= '0;
`endif
    end else begin
      div_q <= div_d;
      h_q <= h_d;
      v_q <= v_d;
      addr_q <= addr_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      act_q <= act_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
      rgb_q <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      frame_q <= frame_d;
`ifdef TEST_PATTERN_EN
      bar_q <= bar_d;
`endif
    end
  end
  assign pixel_read_address_o = addr_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign red_o = rgb_q[11:8];
  assign green_o = rgb_q[7:4];
  assign blue_o = rgb_q[3:0];
  assign video_active_o = video_q;
  assign frame_start_o = frame_q;
endmodule
